// File: rtl/sseg_mux_rx_pkg.sv
// Shared types and constants for the seven-segment mux receiver.
// Glyphs are active-low, bit6..0 = a,b,c,d,e,f,g.
package sseg_mux_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_to_hex.sv
// Combinational glyph decoder: active-low 7-segment pattern to hex digit.
// Minus bar flags neg; blank and unknown patterns decode to 0 with hex_ok low.
module seg_to_hex
  import sseg_mux_rx_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       hex_ok,
  output logic       neg
);

  always_comb begin
    hex    = 4'h0;
    hex_ok = 1'b1;
    neg    = 1'b0;
    case (seg)
      SEG_0:     hex = 4'h0;
      SEG_1:     hex = 4'h1;
      SEG_2:     hex = 4'h2;
      SEG_3:     hex = 4'h3;
      SEG_4:     hex = 4'h4;
      SEG_5:     hex = 4'h5;
      SEG_6:     hex = 4'h6;
      SEG_7:     hex = 4'h7;
      SEG_8:     hex = 4'h8;
      SEG_9:     hex = 4'h9;
      SEG_A:     hex = 4'hA;
      SEG_B:     hex = 4'hB;
      SEG_C:     hex = 4'hC;
      SEG_D:     hex = 4'hD;
      SEG_E:     hex = 4'hE;
      SEG_F:     hex = 4'hF;
      SEG_MINUS: begin
        hex_ok = 1'b0;
        neg    = 1'b1;
      end
      SEG_BLANK: hex_ok = 1'b0;
      default:   hex_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_mux_rx.sv
// Receives a multiplexed 4-digit seven-segment display bus and captures
// each digit once {an,sseg} has been stable for SETTLE cycles.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | an not one-hot-low (blank period or illegal multi-low)
// ST_SETTLE | one digit driven, counting consecutive unchanged cycles
// ST_HOLD   | digit captured, waiting for the bus to change
module sseg_mux_rx
  import sseg_mux_rx_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int TMO_W  = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  sseg,
  output logic [31:0] led,
  output logic [15:0] hex,
  output logic [3:0]  hex_ok,
  output logic [3:0]  neg,
  output logic        frame_tick,
  output logic        stale,
  output logic        err
);

  localparam logic [7:0]       SETTLE_TC = 8'(SETTLE - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = {TMO_W{1'b1}};
  localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};

  state_t           state, state_n;
  logic [7:0]       cnt, cnt_n, eff;
  logic [3:0]       prev_an;
  logic [7:0]       prev_sseg;
  logic [3:0]       seen;
  logic [TMO_W-1:0] tmo;
  logic [1:0]       idx;
  logic             onehot, multi, changed, cap;
  logic [3:0]       dec_hex;
  logic             dec_ok, dec_neg;
  logic [3:0]       dig_bit;

  always_comb begin
    onehot = 1'b1;
    multi  = 1'b0;
    idx    = 2'd0;
    case (an)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      4'b1111: onehot = 1'b0;
      default: begin
        onehot = 1'b0;
        multi  = 1'b1;
      end
    endcase
  end

  assign changed = ({an, sseg} != {prev_an, prev_sseg});
  assign dig_bit = 4'b0001 << idx;

  // eff = consecutive unchanged cycles before this one; the cycle that first
  // presents a value counts as zero, so capture lands on the SETTLE-th cycle.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    eff     = 8'd0;
    if (!onehot) begin
      state_n = ST_IDLE;
      cnt_n   = 8'd0;
    end else begin
      case (state)
        ST_IDLE:   eff = 8'd0;
        ST_SETTLE: eff = changed ? 8'd0 : cnt + 8'd1;
        ST_HOLD:   eff = 8'd0;
        default:   eff = 8'd0;
      endcase
      if (state != ST_HOLD || changed) begin
        if (eff == SETTLE_TC) begin
          cap     = 1'b1;
          state_n = ST_HOLD;
          cnt_n   = 8'd0;
        end else begin
          state_n = ST_SETTLE;
          cnt_n   = eff;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      prev_an   <= 4'hF;
      prev_sseg <= 8'hFF;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      prev_an   <= an;
      prev_sseg <= sseg;
    end
  end

  seg_to_hex u_seg_to_hex (
    .seg    (sseg[6:0]),
    .hex    (dec_hex),
    .hex_ok (dec_ok),
    .neg    (dec_neg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led        <= 32'hFFFF_FFFF;
      hex        <= 16'h0000;
      hex_ok     <= 4'h0;
      neg        <= 4'h0;
      seen       <= 4'h0;
      frame_tick <= 1'b0;
      err        <= 1'b0;
      tmo        <= '0;
    end else begin
      frame_tick <= 1'b0;
      if (multi) err <= 1'b1;
      if (cap) begin
        led[{idx, 3'b000} +: 8] <= sseg;
        hex[{idx, 2'b00} +: 4]  <= dec_hex;
        hex_ok[idx]             <= dec_ok;
        neg[idx]                <= dec_neg;
        if ((seen | dig_bit) == 4'hF) begin
          seen       <= 4'h0;
          frame_tick <= 1'b1;
        end else begin
          seen <= seen | dig_bit;
        end
      end
      if (cap)         tmo <= '0;
      else if (!stale) tmo <= tmo + TMO_ONE;
    end
  end

  assign stale = (tmo == TMO_MAX);

endmodule

// File: doc/sseg_mux_rx.md
SSEG_MUX_RX -- requirements
Module: sseg_mux_rx

Interface
REQ-001 Parameter: SETTLE, default 4, meaning consecutive unchanged cycles of {an,sseg} required before a digit is captured (legal range 1..255).
REQ-002 Parameter: TMO_W, default 20, meaning width of the refresh-timeout counter; timeout fires at 2^TMO_W-1 cycles.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 an  input  4  anode enables from a display multiplexer, active-low, synchronous to clk.
REQ-006 sseg  input  8  segment bus, active-low; bit7=dp, bit6..0=a,b,c,d,e,f,g (bit0=g).
REQ-007 led  output  32  captured raw pattern per digit, led[8i+7:8i] for digit i.
REQ-008 hex  output  16  decoded hex value per digit, hex[4i+3:4i].
REQ-009 hex_ok  output  4  digit i's last capture matched a hex glyph.
REQ-010 neg  output  4  digit i's last capture was the minus bar (7'b1111110).
REQ-011 frame_tick  output  1  one-cycle pulse when all four digits captured since the previous pulse.
REQ-012 stale  output  1  no capture for 2^TMO_W-1 cycles.
REQ-013 err  output  1  sticky: more than one anode low was ever observed.

Function
REQ-014 Inputs are used directly, without synchronizers; digit index i = position of the single low bit of an.
REQ-015 FSM states IDLE, SETTLE, HOLD; encoding in shared package.
REQ-016 IDLE: an not one-hot-low; on one-hot-low an -> SETTLE, settle counter=0.
REQ-017 SETTLE: counter increments each cycle {an,sseg} equals previous-cycle value; any change restarts count (or -> IDLE if an not one-hot-low); at count==SETTLE-1 -> capture, then HOLD.
REQ-018 HOLD: no further capture; any change of an or sseg -> SETTLE (or IDLE if an not one-hot-low).
REQ-019 Capture of digit i: led[i]<=sseg; hex[i], hex_ok[i], neg[i] <= decode of sseg[6:0]; seen[i]<=1; all registered, visible cycle after capture condition.
REQ-020 Decode: 16 standard active-low glyphs 0-F map to 0x0-0xF, hex_ok=1; dp ignored; minus bar gives neg=1, hex=0, hex_ok=0; blank/any other pattern gives hex=0, hex_ok=0, neg=0.
REQ-021 frame_tick asserts the cycle after the capture that makes seen==4'b1111; seen clears that same cycle; recapturing an already-seen digit does not tick.
REQ-022 Timeout counter resets to 0 on every capture, else increments, saturating at 2^TMO_W-1; stale=1 while saturated; stale clears the cycle after the next capture; captured outputs are retained when stale.
REQ-023 err sets the cycle after any an with two or more low bits; FSM treats that as IDLE; err never self-clears.
REQ-024 an all-high (blank period) -> IDLE; captured data retained.

Reset
REQ-025 reset asserted at any time, including mid-SETTLE: FSM=IDLE, counters=0, seen=0, led=all 8'hFF, hex=0, hex_ok=0, neg=0, frame_tick=0, stale=0, err=0.
REQ-026 First capture after reset needs full SETTLE cycles of stable input from deassertion.

Structure
REQ-027 Shared package holds: FSM state encoding, glyph constants for 0-F, SEG_MINUS=7'b1111110, SEG_BLANK=7'b1111111.
REQ-028 One combinational sub-module seg_to_hex (7-bit pattern -> hex, hex_ok, neg) instantiated once, fed by sseg[6:0].

Verification
REQ-029 an=4'b1110, sseg=8'b10000001 stable 4 cycles (SETTLE=4) -> led[7:0]=8'h81, hex[3:0]=0, hex_ok[0]=1 one cycle after the 4th cycle.
REQ-030 Drive the four digits in order with glyphs 3,A,minus,blank, each held 6 cycles -> single frame_tick after digit 3 captures; neg=4'b0100, hex_ok=4'b0011.
REQ-031 an=4'b1101, sseg toggles every 2 cycles -> no capture, hex_ok[1] unchanged, no frame_tick.
REQ-032 an=4'b1100 for one cycle -> err=1 and held through subsequent legal traffic until reset.
REQ-033 TMO_W=4, no legal an for 15 cycles -> stale=1; then valid digit 2 capture -> stale=0 next cycle.
REQ-034 Assert reset during SETTLE of digit 1 with prior captured frame -> all outputs to reset values, next capture requires full SETTLE.
